// File: rtl/key_debounce_multi_if.sv
// Pin-side bundle for the multi-channel key conditioner: raw inputs in, conditioned levels/pulses out.
interface key_debounce_multi_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] raw_in_i;
  logic [NUM_CH-1:0] level_o;
  logic [NUM_CH-1:0] press_o;
  logic [NUM_CH-1:0] release_o;
  logic [NUM_CH-1:0] rpt_o;

  modport master (output raw_in_i, input level_o, press_o, release_o, rpt_o);
  modport slave  (input raw_in_i, output level_o, press_o, release_o, rpt_o);
endinterface

// File: rtl/key_debounce_multi.sv
// N-channel key conditioner: sync, polarity fix, debounce, press/release pulses.
// Hold-to-auto-repeat is built only when AUTO_REPEAT_EN is defined; otherwise rpt is tied low.
module key_debounce_multi #(
  parameter int                NUM_CH       = 4,
  parameter int                CNT_BITS     = 16,
  parameter int                ACTIVE_LOW   = 1,
  parameter int                REPEAT_DELAY = 25000000,
  parameter int                REPEAT_RATE  = 5000000,
  parameter logic [NUM_CH-1:0] REPEAT_MASK  = {NUM_CH{1'b1}}
) (
  input  logic                clk,
  input  logic                reset,
  key_debounce_multi_if.slave kif
);
  // Resetting the synchronisers to the idle pin value avoids a phantom press after reset.
  localparam logic [NUM_CH-1:0] INACT = (ACTIVE_LOW != 0) ? {NUM_CH{1'b1}} : {NUM_CH{1'b0}};

  logic [NUM_CH-1:0] sync0_q, sync1_q, pr;
  logic [NUM_CH-1:0] lvl, rise, fall, prs, rel, rpt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync0_q <= INACT;
      sync1_q <= INACT;
    end else begin
      sync0_q <= kif.raw_in_i;
      sync1_q <= sync0_q;
    end
  end

  assign pr = sync1_q ^ INACT;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                lvl_q, lvl_d, prs_q, rel_q;

    always_comb begin
      cnt_d = cnt_q;
      lvl_d = lvl_q;
      if (pr[i] == lvl_q) begin
        cnt_d = '0;
      end else if (cnt_q != {CNT_BITS{1'b1}}) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        lvl_d = pr[i];
        cnt_d = '0;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
        lvl_q <= 1'b0;
        prs_q <= 1'b0;
        rel_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        lvl_q <= lvl_d;
        prs_q <= lvl_d & ~lvl_q;
        rel_q <= ~lvl_d & lvl_q;
      end
    end

    assign lvl[i]  = lvl_q;
    assign rise[i] = lvl_d & ~lvl_q;
    assign fall[i] = ~lvl_d & lvl_q;
    assign prs[i]  = prs_q;
    assign rel[i]  = rel_q;
  end

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX);

  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} rpt_st_e;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_rpt
    if (REPEAT_MASK[i]) begin : g_on
      rpt_st_e         st_q, st_d;
      logic [RW-1:0]   rc_q, rc_d;
      logic            rp_q, rp_d;

      // A fall wins over a due repeat so rpt never lands on the release edge.
      always_comb begin
        st_d = st_q;
        rc_d = rc_q;
        rp_d = 1'b0;
        unique case (st_q)
          ST_IDLE: begin
            if (rise[i]) begin
              st_d = ST_DELAY;
              rc_d = '0;
            end
          end
          ST_DELAY: begin
            if (fall[i]) begin
              st_d = ST_IDLE;
              rc_d = '0;
            end else if (rc_q == RW'(REPEAT_DELAY - 1)) begin
              st_d = ST_REPEAT;
              rc_d = '0;
              rp_d = 1'b1;
            end else begin
              rc_d = rc_q + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (fall[i]) begin
              st_d = ST_IDLE;
              rc_d = '0;
            end else if (rc_q == RW'(REPEAT_RATE - 1)) begin
              rc_d = '0;
              rp_d = 1'b1;
            end else begin
              rc_d = rc_q + 1'b1;
            end
          end
          default: begin
            st_d = ST_IDLE;
            rc_d = '0;
          end
        endcase
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          st_q <= ST_IDLE;
          rc_q <= '0;
          rp_q <= 1'b0;
        end else begin
          st_q <= st_d;
          rc_q <= rc_d;
          rp_q <= rp_d;
        end
      end

      assign rpt[i] = rp_q;
    end else begin : g_off
      assign rpt[i] = 1'b0;
    end
  end
`else
  assign rpt = '0;
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = ^{REPEAT_MASK, REPEAT_DELAY[0], REPEAT_RATE[0]};
`endif

  logic unused_edges;
  assign unused_edges = ^{rise, fall};

  assign kif.level_o   = lvl;
  assign kif.press_o   = prs;
  assign kif.release_o = rel;
  assign kif.rpt_o     = rpt;
endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi; pulse events are scoreboarded by (cycle, kind, channel).
module tb_key_debounce_multi;
  localparam int         NCH  = 4;
  localparam int         CB   = 4;
  localparam int         DLY  = 40;
  localparam int         RATE = 10;
  localparam logic [3:0] MASK = 4'b0111;
`ifdef AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   sb[$];

  key_debounce_multi_if #(.NUM_CH(NCH)) kif ();

  key_debounce_multi #(
    .NUM_CH(NCH), .CNT_BITS(CB), .ACTIVE_LOW(1),
    .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE), .REPEAT_MASK(MASK)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .kif  (kif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  // kind: 0 press, 1 release, 2 rpt
  function automatic void push(input int c, input int kind, input int ch);
    sb.push_back(c * 16 + kind * 4 + ch);
    sb.sort();
  endfunction

  // Expected pulses for one press debounced at edge e and ending at edge f.
  function automatic void exp_hold(input int ch, input int e, input int f, input bit with_rel);
    push(e, 0, ch);
    if (AUTO && MASK[ch])
      for (int t = e + DLY; t < f; t += RATE) push(t, 2, ch);
    if (with_rel) push(f, 1, ch);
  endfunction

  task automatic wait_neg(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int k = 0; k < 3; k++) begin
        for (int ch = 0; ch < NCH; ch++) begin
          logic b;
          int   key, exp;
          b = (k == 0) ? kif.press_o[ch] : (k == 1) ? kif.release_o[ch] : kif.rpt_o[ch];
          if (b !== 1'b0) begin
            key = cyc * 16 + k * 4 + ch;
            n_cmp++;
            if (sb.size() == 0) begin
              assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_pulse: got kind %0d ch %0d at cycle %0d, expected none", k, ch, cyc);
              end
            end else begin
              exp = sb.pop_front();
              assert (key === exp) else begin
                n_err++;
                $error("FAIL pulse_event: got kind %0d ch %0d cyc %0d, expected kind %0d ch %0d cyc %0d",
                       k, ch, cyc, (exp % 16) / 4, exp % 4, exp / 16);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    int c, e, f, r, e2, f2;
    reset = 1'b1;
    kif.raw_in_i = 4'hF;

    // reset state, then a quiet 100 cycles
    wait_neg(3);
    chk("rst_level", kif.level_o, 4'h0);
    chk("rst_press", kif.press_o, 4'h0);
    chk("rst_release", kif.release_o, 4'h0);
    chk("rst_rpt", kif.rpt_o, 4'h0);
    reset = 1'b0;
    wait_neg(cyc + 100);
    chk("idle_level", kif.level_o, 4'h0);

    // single clean press on ch0
    c = cyc; kif.raw_in_i[0] = 1'b0; e = c + 18; f = e + 48;
    exp_hold(0, e, f, 1'b1);
    wait_neg(e - 1); chk("A_level_early", kif.level_o, 4'h0);
    wait_neg(e);     chk("A_level", kif.level_o, 4'b0001);
    wait_neg(e + 30); kif.raw_in_i[0] = 1'b1;
    wait_neg(f - 1); chk("A_level_hold", kif.level_o, 4'b0001);
    wait_neg(f);     chk("A_level_rel", kif.level_o, 4'h0);

    // bouncing ch1: only the final settle counts
    for (int i = 0; i < 12; i++) begin
      kif.raw_in_i[1] = (i % 2) != 0;
      wait_neg(cyc + 5);
    end
    kif.raw_in_i[1] = 1'b0; c = cyc; e = c + 18; f = e + 23;
    exp_hold(1, e, f, 1'b1);
    wait_neg(e - 1); chk("B_level_early", kif.level_o, 4'h0);
    wait_neg(e);     chk("B_level", kif.level_o, 4'b0010);
    wait_neg(e + 5); kif.raw_in_i[1] = 1'b1;
    wait_neg(f);     chk("B_level_rel", kif.level_o, 4'h0);

    // long hold on ch2 with auto-repeat
    c = cyc; kif.raw_in_i[2] = 1'b0; e = c + 18; f = e + 118;
    exp_hold(2, e, f, 1'b1);
    wait_neg(e);       chk("C_level", kif.level_o, 4'b0100);
    wait_neg(e + 39);  chk("C_rpt_early", kif.rpt_o, 4'h0);
    wait_neg(e + 40);  chk("C_rpt_first", kif.rpt_o, AUTO ? 4'b0100 : 4'h0);
    wait_neg(e + 100); kif.raw_in_i[2] = 1'b1;
    wait_neg(f);       chk("C_release", kif.release_o, 4'b0100);

    // simultaneous ch0+ch3; ch3 has repeat masked off
    c = cyc; kif.raw_in_i[0] = 1'b0; kif.raw_in_i[3] = 1'b0; e = c + 18; f = e + 63;
    exp_hold(0, e, f, 1'b1);
    exp_hold(3, e, f, 1'b1);
    wait_neg(e);      chk("D_press", kif.press_o, 4'b1001);
    wait_neg(e + 40); chk("D_rpt", kif.rpt_o, AUTO ? 4'b0001 : 4'h0);
    wait_neg(e + 45); kif.raw_in_i[0] = 1'b1; kif.raw_in_i[3] = 1'b1;
    wait_neg(f);      chk("D_release", kif.release_o, 4'b1001);

    // reset in the middle of repeating on ch2, key still held
    c = cyc; kif.raw_in_i[2] = 1'b0; e = c + 18; r = e + 56;
    exp_hold(2, e, r, 1'b0);
    wait_neg(e + 55); reset = 1'b1;
    wait_neg(r);
    chk("E_rst_level", kif.level_o, 4'h0);
    chk("E_rst_press", kif.press_o, 4'h0);
    chk("E_rst_release", kif.release_o, 4'h0);
    chk("E_rst_rpt", kif.rpt_o, 4'h0);
    reset = 1'b0; e2 = r + 18; f2 = e2 + 20;
    exp_hold(2, e2, f2, 1'b1);
    wait_neg(e2 - 1); chk("E_level_early", kif.level_o, 4'h0);
    wait_neg(e2);     chk("E_repress", kif.press_o, 4'b0100);
    wait_neg(e2 + 2); kif.raw_in_i[2] = 1'b1;
    wait_neg(f2 + 5); chk("E_level_end", kif.level_o, 4'h0);

    n_cmp++;
    assert (sb.size() == 0) else begin
      n_err++;
      $error("FAIL scoreboard_drain: got %0d pending events, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
